bounds_table_dlk: RTL

BOUNDS_TABLE_DLK -- requirements
Module: bounds_table_dlk

---
 rtl/bounds_table_dlk_if.sv | 42 ++++
 rtl/bounds_table_dlk.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bounds_table_dlk_if.sv
// Handshake/bus bundle for the bounds table.
interface bounds_table_dlk_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alloc_valid_i;
    logic          alloc_ready_o;
    logic [AW-1:0] alloc_base_i;
    logic [AW-1:0] alloc_size_i;
    logic          free_valid_i;
    logic [AW-1:0] free_base_i;
    logic          chk_valid_i;
    logic [AW-1:0] chk_base_i;
    logic [AW-1:0] chk_addr_i;
    logic          chk_valid_o;
    logic          chk_hit_o;
    logic          chk_violation_o;
    logic          evict_o;
    logic          alloc_err_o;
    logic [CW-1:0] count_o;
    logic          full_o;

    modport master (
        output alloc_valid_i, alloc_base_i, alloc_size_i,
        output free_valid_i, free_base_i,
        output chk_valid_i, chk_base_i, chk_addr_i,
        input  alloc_ready_o, chk_valid_o, chk_hit_o,
        input  chk_violation_o, evict_o, alloc_err_o,
        input  count_o, full_o
    );

    modport slave (
        input  alloc_valid_i, alloc_base_i, alloc_size_i,
        input  free_valid_i, free_base_i,
        input  chk_valid_i, chk_base_i, chk_addr_i,
        output alloc_ready_o, chk_valid_o, chk_hit_o,
        output chk_violation_o, evict_o, alloc_err_o,
        output count_o, full_o
    );
endinterface

// File: rtl/bounds_table_dlk.sv
// Region bounds table: insert/free/check with round-robin eviction.
// Define DLK_NEAREST_EN to flag misses that land in the next region up.
module bounds_table_dlk #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    bounds_table_dlk_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0] valid_q, valid_n, valid_f;
    logic [AW-1:0]    base_q  [DEPTH];
    logic [AW-1:0]    base_n  [DEPTH];
    logic [AW:0]      limit_q [DEPTH];
    logic [AW:0]      limit_n [DEPTH];
    logic [IW-1:0]    cursor_q, cursor_n;
    logic [CW-1:0]    count_q, count_n;
    logic             full_q, chk_v_q, hit_q, viol_q;
    logic             evict_q, err_q;

    logic          clr;
    logic          chk_hit, hit_viol, miss_viol;
    logic [AW:0]   chk_lim;
    logic          do_alloc, zero_sz, wr, evict;
    logic          upd_hit, free_slot;
    logic [IW-1:0] upd_idx, free_idx, wr_idx;
    logic [AW:0]   new_lim;

    assign clr = rst_i | flush_i;
    assign bus.alloc_ready_o = ~clr;

    always_comb begin
        chk_hit = 1'b0;
        chk_lim = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!chk_hit && valid_q[i] &&
                base_q[i] == bus.chk_base_i) begin
                chk_hit = 1'b1;
                chk_lim = limit_q[i];
            end
        end
    end

    assign hit_viol = (bus.chk_addr_i < bus.chk_base_i) ||
                      ({1'b0, bus.chk_addr_i} >= chk_lim);

`ifdef DLK_NEAREST_EN
    logic          near_found;
    logic [AW-1:0] near_base;

    // smallest valid base strictly above the probed base
    always_comb begin
        near_found = 1'b0;
        near_base  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && base_q[i] > bus.chk_base_i &&
                (!near_found || base_q[i] < near_base)) begin
                near_found = 1'b1;
                near_base  = base_q[i];
            end
        end
    end

    assign miss_viol = near_found && (near_base <= bus.chk_addr_i);
`else
    assign miss_viol = 1'b0;
`endif

    assign new_lim = {1'b0, bus.alloc_base_i} +
                     {1'b0, bus.alloc_size_i};

    // free is applied first, so the insert search sees valid_f
    always_comb begin
        valid_f = valid_q;
        if (bus.free_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && base_q[i] == bus.free_base_i)
                    valid_f[i] = 1'b0;
            end
        end
        upd_hit   = 1'b0;
        upd_idx   = '0;
        free_slot = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!upd_hit && valid_f[i] &&
                base_q[i] == bus.alloc_base_i) begin
                upd_hit = 1'b1;
                upd_idx = IW'(i);
            end
            if (!free_slot && !valid_f[i]) begin
                free_slot = 1'b1;
                free_idx  = IW'(i);
            end
        end
    end

    assign do_alloc = bus.alloc_valid_i & ~clr;
    assign zero_sz  = (bus.alloc_size_i == '0);
    assign wr       = do_alloc & ~zero_sz;
    assign evict    = wr & ~upd_hit & ~free_slot;
    assign wr_idx   = upd_hit   ? upd_idx  :
                      free_slot ? free_idx : cursor_q;

    always_comb begin
        valid_n  = valid_f;
        base_n   = base_q;
        limit_n  = limit_q;
        cursor_n = cursor_q;
        if (wr) begin
            valid_n[wr_idx] = 1'b1;
            base_n[wr_idx]  = bus.alloc_base_i;
            limit_n[wr_idx] = new_lim;
        end
        if (evict)
            cursor_n = cursor_q + IW'(1);
        count_n = '0;
        for (int i = 0; i < DEPTH; i++)
            count_n = count_n + CW'(valid_n[i]);
    end

    always_ff @(posedge clk_i) begin
        if (clr) begin
            valid_q  <= '0;
            cursor_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            chk_v_q  <= 1'b0;
            hit_q    <= 1'b0;
            viol_q   <= 1'b0;
            evict_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_n;
            cursor_q <= cursor_n;
            count_q  <= count_n;
            full_q   <= (count_n == CW'(DEPTH));
            chk_v_q  <= bus.chk_valid_i;
            hit_q    <= bus.chk_valid_i & chk_hit;
            viol_q   <= bus.chk_valid_i &
                        (chk_hit ? hit_viol : miss_viol);
            evict_q  <= evict;
            err_q    <= do_alloc & zero_sz;
        end
    end

    // payload only matters under valid, so it carries no reset
    always_ff @(posedge clk_i) begin
        base_q  <= base_n;
        limit_q <= limit_n;
    end

    assign bus.chk_valid_o     = chk_v_q;
    assign bus.chk_hit_o       = hit_q;
    assign bus.chk_violation_o = viol_q;
    assign bus.evict_o         = evict_q;
    assign bus.alloc_err_o     = err_q;
    assign bus.count_o         = count_q;
    assign bus.full_o          = full_q;
endmodule
